dpram_be: RTL and testbench



---
 rtl/dpram_be.sv | 189 ++++++++++++++++++
 tb/tb_dpram_be.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be.sv
// ---------------------------------------------------------------------------
// dpram_be -- true dual-port RAM, single clock, per-byte write enables.
//
// Two independent read/write ports (A and B) share one array. Features:
//   * per-lane write enables (lanes = data_width / byte_width)
//   * read latency of 1 or 2 enabled clock edges
//   * per-port read-during-write mode (old data or merged new data)
//   * same-address collision: lanes enabled on both ports take port B's data
//   * post-reset fill engine writing clear_value to every word; busy while
//     held in reset or filling
//
// Ports (X = a or b):
//   clock       sole clock
//   reset       synchronous, active-high
//   address_X   word address
//   data_X      write data
//   byteena_X   lane write enables
//   enable_X    port clock enable (freezes reads and blocks writes when low)
//   wren_X      write request
//   cs_X        chip select; also gates q_X combinationally
//   q_X         read data, or the disable pattern when cs_X is low
//   busy        high from reset until the fill engine has finished
// ---------------------------------------------------------------------------
module dpram_be #(
    parameter int                    addr_width     = 8,
    parameter int                    data_width     = 16,
    parameter int                    byte_width     = 8,
    parameter int                    read_latency   = 1,
    parameter int                    rdw_new_a      = 0,
    parameter int                    rdw_new_b      = 0,
    parameter int                    clear_on_reset = 1,
    parameter logic [data_width-1:0] clear_value    = '0,
    parameter logic                  disable_value  = 1'b1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [addr_width-1:0]            address_a,
    input  logic [data_width-1:0]            data_a,
    input  logic [data_width/byte_width-1:0] byteena_a,
    input  logic                             enable_a,
    input  logic                             wren_a,
    input  logic                             cs_a,
    output logic [data_width-1:0]            q_a,
    input  logic [addr_width-1:0]            address_b,
    input  logic [data_width-1:0]            data_b,
    input  logic [data_width/byte_width-1:0] byteena_b,
    input  logic                             enable_b,
    input  logic                             wren_b,
    input  logic                             cs_b,
    output logic [data_width-1:0]            q_b,
    output logic                             busy
);

    localparam int lanes = data_width / byte_width;
    localparam int depth = 2 ** addr_width;

    // Reject unsupported configurations at elaboration time.
    if (read_latency != 1 && read_latency != 2) begin : g_bad_latency
        $error("dpram_be: read_latency must be 1 or 2");
    end
    if (data_width % byte_width != 0) begin : g_bad_lanes
        $error("dpram_be: data_width must be a multiple of byte_width");
    end

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Replace the enabled lanes of old_w with the corresponding lanes of new_w.
    function automatic logic [data_width-1:0] merge_lanes(
        input logic [data_width-1:0] old_w,
        input logic [data_width-1:0] new_w,
        input logic [lanes-1:0]      be
    );
        logic [data_width-1:0] res;
        res = old_w;
        for (int i = 0; i < lanes; i++) begin
            if (be[i]) res[i*byte_width +: byte_width] = new_w[i*byte_width +: byte_width];
        end
        return res;
    endfunction

    logic [data_width-1:0] r_mem [depth];
    state_t                r_state;
    logic [addr_width-1:0] r_fill_cnt;
    logic                  r_busy;
    logic [data_width-1:0] r_s1_a, r_s2_a, r_s1_b, r_s2_b;

    logic                  w_run_a, w_run_b;
    logic                  w_wr_a, w_wr_b;
    logic [data_width-1:0] w_old_a, w_old_b;
    logic [data_width-1:0] w_merged_a, w_merged_b;
    logic [data_width-1:0] w_base_b, w_word_b;
    logic [data_width-1:0] w_pipe_a, w_pipe_b;

    // Ports only act in IDLE, never on an edge where reset is sampled high.
    assign w_run_a = (r_state == ST_IDLE) && !reset && enable_a;
    assign w_run_b = (r_state == ST_IDLE) && !reset && enable_b;
    assign w_wr_a  = w_run_a && cs_a && wren_a;
    assign w_wr_b  = w_run_b && cs_b && wren_b;

    assign w_old_a    = r_mem[address_a];
    assign w_old_b    = r_mem[address_b];
    assign w_merged_a = merge_lanes(w_old_a, data_a, byteena_a);
    assign w_merged_b = merge_lanes(w_old_b, data_b, byteena_b);

    // On a same-address collision port B is layered on top of port A's
    // merged word, so B wins shared lanes and A keeps its exclusive lanes.
    assign w_base_b = (w_wr_a && (address_a == address_b)) ? w_merged_a : w_old_b;
    assign w_word_b = merge_lanes(w_base_b, data_b, byteena_b);

    // Fill-engine FSM with registered busy.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_HOLD;
            r_fill_cnt <= '0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (clear_on_reset != 0) begin
                        r_state <= ST_CLEAR;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (&r_fill_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: begin
                    r_state <= ST_HOLD;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array writes: fill engine, then port A, then port B (collision word).
    // NOTE: the array deliberately has no reset; contents survive reset and
    // are initialised by the fill engine instead.
    always_ff @(posedge clock) begin
        if (!reset && r_state == ST_CLEAR) begin
            r_mem[r_fill_cnt] <= clear_value;
        end else begin
            if (w_wr_a) r_mem[address_a] <= w_merged_a;
            if (w_wr_b) r_mem[address_b] <= w_word_b;
        end
    end

    // Read pipelines: stage 1 captures every enabled edge; stage 2 follows.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_a <= '0;
            r_s2_a <= '0;
        end else if (w_run_a) begin
            r_s1_a <= (rdw_new_a != 0 && w_wr_a) ? w_merged_a : w_old_a;
            r_s2_a <= r_s1_a;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_b <= '0;
            r_s2_b <= '0;
        end else if (w_run_b) begin
            r_s1_b <= (rdw_new_b != 0 && w_wr_b) ? w_merged_b : w_old_b;
            r_s2_b <= r_s1_b;
        end
    end

    assign w_pipe_a = (read_latency == 2) ? r_s2_a : r_s1_a;
    assign w_pipe_b = (read_latency == 2) ? r_s2_b : r_s1_b;

    // Chip-select gating is combinational on the current cs.
    assign q_a  = cs_a ? w_pipe_a : {data_width{disable_value}};
    assign q_b  = cs_b ? w_pipe_b : {data_width{disable_value}};
    assign busy = r_busy;

endmodule

// File: tb/tb_dpram_be.sv
// ---------------------------------------------------------------------------
// tb_dpram_be -- self-checking bench for dpram_be.
// u_dut : addr_width 4, fill A5A5, read_latency 1, rdw_new_a 0, rdw_new_b 1
// u_dut2: addr_width 4, fill A5A5, read_latency 2
// ---------------------------------------------------------------------------
module tb_dpram_be;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT 1 signals ----------------
    logic [3:0]  address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic [1:0]  byteena_a = '0, byteena_b = '0;
    logic        enable_a = 1'b0, enable_b = 1'b0;
    logic        wren_a = 1'b0, wren_b = 1'b0;
    logic        cs_a = 1'b1, cs_b = 1'b0;
    logic [15:0] q_a, q_b;
    logic        busy;

    // ---------------- DUT 2 signals ----------------
    logic [3:0]  address_a2 = '0, address_b2 = '0;
    logic [15:0] data_a2 = '0, data_b2 = '0;
    logic [1:0]  byteena_a2 = '0, byteena_b2 = '0;
    logic        enable_a2 = 1'b0, enable_b2 = 1'b0;
    logic        wren_a2 = 1'b0, wren_b2 = 1'b0;
    logic        cs_a2 = 1'b1, cs_b2 = 1'b1;
    logic [15:0] q_a2, q_b2;
    logic        busy2;

    dpram_be #(
        .addr_width(4), .data_width(16), .byte_width(8), .read_latency(1),
        .rdw_new_a(0), .rdw_new_b(1), .clear_on_reset(1),
        .clear_value(16'hA5A5), .disable_value(1'b1)
    ) u_dut (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
        .enable_a(enable_a), .wren_a(wren_a), .cs_a(cs_a), .q_a(q_a),
        .address_b(address_b), .data_b(data_b), .byteena_b(byteena_b),
        .enable_b(enable_b), .wren_b(wren_b), .cs_b(cs_b), .q_b(q_b),
        .busy(busy)
    );

    dpram_be #(
        .addr_width(4), .data_width(16), .byte_width(8), .read_latency(2),
        .rdw_new_a(0), .rdw_new_b(0), .clear_on_reset(1),
        .clear_value(16'hA5A5), .disable_value(1'b1)
    ) u_dut2 (
        .clock(clock), .reset(reset),
        .address_a(address_a2), .data_a(data_a2), .byteena_a(byteena_a2),
        .enable_a(enable_a2), .wren_a(wren_a2), .cs_a(cs_a2), .q_a(q_a2),
        .address_b(address_b2), .data_b(data_b2), .byteena_b(byteena_b2),
        .enable_b(enable_b2), .wren_b(wren_b2), .cs_b(cs_b2), .q_b(q_b2),
        .busy(busy2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One vector = one clock edge on DUT 1, q sampled #1 after that edge.
    typedef struct {
        logic        en_a, wr_a, cs_a;
        logic [3:0]  addr_a;
        logic [15:0] data_a;
        logic [1:0]  be_a;
        logic        en_b, wr_b, cs_b;
        logic [3:0]  addr_b;
        logic [15:0] data_b;
        logic [1:0]  be_b;
        logic        chk_a;
        logic [15:0] exp_a;
        logic        chk_b;
        logic [15:0] exp_b;
    } vec_t;

    function automatic vec_t mk(
        input logic ea, input logic wa, input logic ca, input logic [3:0] aa,
        input logic [15:0] da, input logic [1:0] ba,
        input logic eb, input logic wb, input logic cb, input logic [3:0] ab,
        input logic [15:0] db, input logic [1:0] bb,
        input logic ka, input logic [15:0] xa, input logic kb, input logic [15:0] xb
    );
        vec_t v;
        v.en_a = ea; v.wr_a = wa; v.cs_a = ca; v.addr_a = aa; v.data_a = da; v.be_a = ba;
        v.en_b = eb; v.wr_b = wb; v.cs_b = cb; v.addr_b = ab; v.data_b = db; v.be_b = bb;
        v.chk_a = ka; v.exp_a = xa; v.chk_b = kb; v.exp_b = xb;
        return v;
    endfunction

    // Release reset and count edges that leave busy high (bounded).
    task automatic release_and_count(output int n);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (busy) n++;
            else break;
        end
    endtask

    vec_t vecs [17];
    int   n_busy;

    initial begin
        // Port A columns, then port B columns, then expectations.
        //          en wr cs addr data      be     en wr cs addr data      be     ka exp_a     kb exp_b
        // byte lanes at address 3
        vecs[0]  = mk(1, 1, 1, 4'd3, 16'h1234, 2'b11, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'hA5A5, 0, 16'h0000);
        vecs[1]  = mk(1, 0, 1, 4'd3, 16'h0000, 2'b00, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'h1234, 0, 16'h0000);
        vecs[2]  = mk(1, 1, 1, 4'd3, 16'hBEEF, 2'b10, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'h1234, 0, 16'h0000);
        vecs[3]  = mk(1, 0, 1, 4'd3, 16'h0000, 2'b00, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'hBE34, 0, 16'h0000);
        vecs[4]  = mk(1, 1, 1, 4'd3, 16'h0000, 2'b00, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'hBE34, 0, 16'h0000);
        vecs[5]  = mk(1, 0, 1, 4'd3, 16'h0000, 2'b00, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'hBE34, 0, 16'h0000);
        // read-during-write at address 5 (set to 0 first)
        vecs[6]  = mk(1, 1, 1, 4'd5, 16'h0000, 2'b11, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'hA5A5, 0, 16'h0000);
        vecs[7]  = mk(1, 1, 1, 4'd5, 16'h7777, 2'b11, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'h0000, 0, 16'h0000);
        vecs[8]  = mk(1, 1, 1, 4'd5, 16'h0000, 2'b11, 0, 0, 1, 4'd0, 16'h0000, 2'b00, 1, 16'h7777, 0, 16'h0000);
        vecs[9]  = mk(1, 0, 1, 4'd5, 16'h0000, 2'b00, 1, 1, 1, 4'd5, 16'h7777, 2'b11, 1, 16'h0000, 1, 16'h7777);
        vecs[10] = mk(1, 0, 1, 4'd5, 16'h0000, 2'b00, 1, 0, 0, 4'd5, 16'h0000, 2'b00, 1, 16'h7777, 1, 16'hFFFF);
        // collisions at address 9
        vecs[11] = mk(1, 1, 1, 4'd9, 16'h1111, 2'b11, 1, 1, 1, 4'd9, 16'h2222, 2'b01, 1, 16'hA5A5, 0, 16'h0000);
        vecs[12] = mk(1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 16'h1122, 1, 16'h1122);
        vecs[13] = mk(1, 1, 1, 4'd9, 16'h3344, 2'b01, 1, 1, 1, 4'd9, 16'h5566, 2'b10, 1, 16'h1122, 0, 16'h0000);
        vecs[14] = mk(1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 16'h5544, 1, 16'h5544);
        // disabled port and deselected port must not write
        vecs[15] = mk(0, 1, 0, 4'd9, 16'h0000, 2'b11, 1, 1, 0, 4'd9, 16'h0000, 2'b11, 1, 16'hFFFF, 1, 16'hFFFF);
        vecs[16] = mk(1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 0, 1, 4'd9, 16'h0000, 2'b00, 1, 16'h5544, 1, 16'h5544);

        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_q_a", q_a, 16'h0000);
        check("reset_q_b_disabled", q_b, 16'hFFFF);
        check("reset_busy", {15'd0, busy}, 16'h0001);
        check("reset_q_a2", q_a2, 16'h0000);

        // ---------------- full fill ----------------
        release_and_count(n_busy);
        check("fill_busy_edges", 16'(n_busy), 16'd16);
        check("fill_busy_low", {15'd0, busy}, 16'h0000);
        check("fill_busy2_low", {15'd0, busy2}, 16'h0000);

        // ---------------- reset in the middle of a fill ----------------
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (8) @(posedge clock);   // release edge + 7 fill edges: counter = 7
        #1;
        check("midfill_busy", {15'd0, busy}, 16'h0001);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midfill_reset_busy", {15'd0, busy}, 16'h0001);
        release_and_count(n_busy);
        check("refill_busy_edges", 16'(n_busy), 16'd16);

        // ---------------- readback of the fill ----------------
        cs_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address_a = 4'(i); enable_a = 1'b1; wren_a = 1'b0; cs_a = 1'b1;
            @(posedge clock); #1;
            check($sformatf("fill_read_%0d", i), q_a, 16'hA5A5);
        end

        // ---------------- table-driven vectors on DUT 1 ----------------
        for (int i = 0; i < 17; i++) begin
            enable_a = vecs[i].en_a; wren_a = vecs[i].wr_a; cs_a = vecs[i].cs_a;
            address_a = vecs[i].addr_a; data_a = vecs[i].data_a; byteena_a = vecs[i].be_a;
            enable_b = vecs[i].en_b; wren_b = vecs[i].wr_b; cs_b = vecs[i].cs_b;
            address_b = vecs[i].addr_b; data_b = vecs[i].data_b; byteena_b = vecs[i].be_b;
            @(posedge clock); #1;
            if (vecs[i].chk_a) check($sformatf("vec%0d_q_a", i), q_a, vecs[i].exp_a);
            if (vecs[i].chk_b) check($sformatf("vec%0d_q_b", i), q_b, vecs[i].exp_b);
        end
        enable_a = 1'b0; enable_b = 1'b0; wren_a = 1'b0; wren_b = 1'b0;

        // ---------------- read latency 2 on DUT 2 ----------------
        enable_a2 = 1'b1; cs_a2 = 1'b1; byteena_a2 = 2'b11;
        wren_a2 = 1'b1; address_a2 = 4'd1; data_a2 = 16'h1111;
        @(posedge clock); #1;
        address_a2 = 4'd2; data_a2 = 16'h2222;
        @(posedge clock); #1;
        wren_a2 = 1'b0; address_a2 = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        check("lat2_settled", q_a2, 16'hA5A5);
        address_a2 = 4'd1;                 // captured at edge N
        @(posedge clock); #1;
        check("lat2_edge_n", q_a2, 16'hA5A5);
        address_a2 = 4'd2;
        @(posedge clock); #1;
        check("lat2_edge_n1", q_a2, 16'h1111);
        address_a2 = 4'd3;
        @(posedge clock); #1;
        check("lat2_edge_n2", q_a2, 16'h2222);

        // enable low for 3 cycles: both stages freeze
        enable_a2 = 1'b0; address_a2 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check($sformatf("lat2_hold_%0d", i), q_a2, 16'h2222);
        end

        // combinational chip-select gating
        cs_a2 = 1'b0; #1;
        check("lat2_cs_low", q_a2, 16'hFFFF);
        cs_a2 = 1'b1; #1;
        check("lat2_cs_high", q_a2, 16'h2222);

        // resume: frozen stage 1 (address 3) emerges first, then address 1
        enable_a2 = 1'b1;
        @(posedge clock); #1;
        check("lat2_resume_0", q_a2, 16'hA5A5);
        @(posedge clock); #1;
        check("lat2_resume_1", q_a2, 16'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
